// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller.
//   - BCD digit geometry and per-digit limits
//   - 2-bit state codes (STOP/RUN/PAUSE/LAP)
//   - next-state helper used by the top-level FSM
package stopwatch_ctrl_pkg;

  localparam int BCD_W_DEF        = 4;
  localparam int SEC_TENS_MAX_DEF = 5;
  localparam int MIN_TENS_MAX_DEF = 5;
  localparam int ONES_MAX         = 9;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] STAT_STOP  = 2'd0;
  localparam logic [1:0] STAT_RUN   = 2'd1;
  localparam logic [1:0] STAT_PAUSE = 2'd2;
  localparam logic [1:0] STAT_LAP   = 2'd3;

  // A long-press edge always takes priority over a coincident short press.
  function automatic logic [1:0] next_state(input logic [1:0] cur,
                                            input logic       short_p,
                                            input logic       long_e);
    logic [1:0] nxt;
    nxt = cur;
    if (long_e) begin
      nxt = (cur == STAT_RUN) ? STAT_LAP : STAT_STOP;
    end else if (short_p) begin
      nxt = (cur == STAT_RUN) ? STAT_PAUSE : STAT_RUN;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One BCD digit of the stopwatch ripple chain.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear, overrides inc
//   inc        : advance by one this cycle
//   value      : registered digit value
//   carry      : high when this digit wraps from LIMIT to 0 (feeds next digit's inc)
module bcd_digit_counter #(
  parameter int LIMIT = 9,
  parameter int BCD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  localparam logic [BCD_W-1:0] LIMIT_V = BCD_W'(LIMIT);

  logic [BCD_W-1:0] value_q;
  logic [BCD_W-1:0] value_d;
  logic             at_max;

  assign at_max = (value_q == LIMIT_V);

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & at_max & ~clr;

endmodule

// File: rtl/stopwatch_ctrl.sv
// mm:ss BCD stopwatch controller.
//   short press = start/pause, long press = lap/clear.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   tick_1hz              : one-cycle 1 Hz count enable
//   short_press           : one-cycle pulse from the press detector
//   long_press            : level, high while a long hold persists (acts on rising edge)
//   digit3..digit0        : displayed mm:ss in BCD (lap value while in LAP)
//   running               : high in RUN or LAP
//   lap_mode              : high in LAP (display frozen)
//   overflow              : one-cycle pulse when time wraps from max to 00:00
//
// state | meaning
// ------+--------------------------------------------------------
// STOP  | counter held at 00:00
// RUN   | counting on tick_1hz, live display
// PAUSE | counter frozen, live display
// LAP   | counting continues, display shows latched lap value
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter int BCD_W        = BCD_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             short_press,
  input  logic             long_press,
  output logic [BCD_W-1:0] digit3,
  output logic [BCD_W-1:0] digit2,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit0,
  output logic             running,
  output logic             lap_mode,
  output logic             overflow
);

  localparam int TIME_W = 4 * BCD_W;

  logic [1:0]        state_q, state_d;
  logic              long_dly_q, long_dly_d;
  logic [TIME_W-1:0] lap_q, lap_d;
  logic              overflow_q, overflow_d;

  logic              long_edge;
  logic              clr;
  logic              count_en;
  logic [TIME_W-1:0] live;
  logic [TIME_W-1:0] disp;
  logic [BCD_W-1:0]  cnt0, cnt1, cnt2, cnt3;
  logic              carry0, carry1, carry2, carry3;

  assign long_edge = long_press & ~long_dly_q;

  always_comb begin
    state_d    = next_state(state_q, short_press, long_edge);
    long_dly_d = long_press;
    lap_d      = lap_q;
    if ((state_q == STAT_RUN) && long_edge) begin
      lap_d = live;
    end
    overflow_d = carry3;
  end

  // Entering or sitting in STOP clears the chain and beats any coincident tick.
  // Counting is qualified by the current state, so the tick that arrives with
  // RUN->PAUSE still lands.
  assign clr      = (state_d == STAT_STOP);
  assign count_en = tick_1hz & ((state_q == STAT_RUN) | (state_q == STAT_LAP)) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STAT_STOP;
      long_dly_q <= FALSE;
      lap_q      <= '0;
      overflow_q <= FALSE;
    end else begin
      state_q    <= state_d;
      long_dly_q <= long_dly_d;
      lap_q      <= lap_d;
      overflow_q <= overflow_d;
    end
  end

  bcd_digit_counter #(.LIMIT(ONES_MAX), .BCD_W(BCD_W)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(count_en), .value(cnt0), .carry(carry0)
  );

  bcd_digit_counter #(.LIMIT(SEC_TENS_MAX), .BCD_W(BCD_W)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry0), .value(cnt1), .carry(carry1)
  );

  bcd_digit_counter #(.LIMIT(ONES_MAX), .BCD_W(BCD_W)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry1), .value(cnt2), .carry(carry2)
  );

  bcd_digit_counter #(.LIMIT(MIN_TENS_MAX), .BCD_W(BCD_W)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry2), .value(cnt3), .carry(carry3)
  );

  assign live = {cnt3, cnt2, cnt1, cnt0};

  always_comb begin
    disp     = (state_q == STAT_LAP) ? lap_q : live;
    digit3   = disp[4*BCD_W-1 -: BCD_W];
    digit2   = disp[3*BCD_W-1 -: BCD_W];
    digit1   = disp[2*BCD_W-1 -: BCD_W];
    digit0   = disp[BCD_W-1   -: BCD_W];
  end

  assign running  = (state_q == STAT_RUN) | (state_q == STAT_LAP);
  assign lap_mode = (state_q == STAT_LAP);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       short_press;
  logic       long_press;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       running;
  logic       lap_mode;
  logic       overflow;

  int n_vec  = 0;
  int n_miss = 0;

  stopwatch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .short_press(short_press), .long_press(long_press),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .running(running), .lap_mode(lap_mode), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // advance one clock; inputs driven now are sampled at this edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step();
    end
    tick_1hz = 1'b0;
  endtask

  task automatic short_p();
    short_press = 1'b1;
    step();
    short_press = 1'b0;
  endtask

  task automatic long_p();
    long_press = 1'b1;
    step();
    long_press = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; short_press = 1'b0; long_press = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // 1 reset state
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_lap", {15'd0, lap_mode}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    rst_n = 1'b1;
    step();
    ticks(2);
    chk("stop_no_count", disp(), 16'h0000);

    // 2 start, count, pause
    short_p();
    chk("t2_running", {15'd0, running}, 16'd1);
    ticks(12);
    chk("t2_12s", disp(), 16'h0012);
    short_p();
    chk("t2_paused", {15'd0, running}, 16'd0);
    ticks(3);
    chk("t2_pause_hold", disp(), 16'h0012);

    // 3 tick coincident with RUN->PAUSE still counts
    long_p();
    chk("t3_clear", disp(), 16'h0000);
    short_p();
    ticks(9);
    chk("t3_0009", disp(), 16'h0009);
    tick_1hz = 1'b1; short_press = 1'b1;
    step();
    tick_1hz = 1'b0; short_press = 1'b0;
    chk("t3_disp", disp(), 16'h0010);
    chk("t3_paused", {15'd0, running}, 16'd0);

    // 4 held long press enters LAP once; display frozen while counting
    long_p();
    short_p();
    ticks(65);
    chk("t4_0105", disp(), 16'h0105);
    long_press = 1'b1;
    step();
    chk("t4_lap", {15'd0, lap_mode}, 16'd1);
    chk("t4_frozen0", disp(), 16'h0105);
    for (int i = 0; i < 19; i++) begin
      tick_1hz = (i < 4);
      step();
    end
    tick_1hz = 1'b0;
    long_press = 1'b0;
    step();
    chk("t4_still_lap", {15'd0, lap_mode}, 16'd1);
    chk("t4_frozen1", disp(), 16'h0105);
    short_p();
    chk("t4_run", {16'd0} | {14'd0, running, lap_mode}, 16'b10);
    chk("t4_live", disp(), 16'h0109);

    // 5 wrap from 59:59
    long_p();
    chk("t5_lap2", {15'd0, lap_mode}, 16'd1);
    long_p();
    chk("t5_stop", disp(), 16'h0000);
    short_p();
    ticks(3598);
    chk("t5_5958", disp(), 16'h5958);
    ticks(1);
    chk("t5_5959", disp(), 16'h5959);
    chk("t5_no_ovf", {15'd0, overflow}, 16'd0);
    ticks(1);
    chk("t5_wrap", disp(), 16'h0000);
    chk("t5_ovf", {15'd0, overflow}, 16'd1);
    step();
    chk("t5_ovf_pulse", {15'd0, overflow}, 16'd0);
    chk("t5_still_run", {15'd0, running}, 16'd1);
    ticks(1);
    chk("t5_continue", disp(), 16'h0001);

    // 6 PAUSE: long edge beats short -> STOP
    long_p();
    long_p();
    short_p();
    ticks(150);
    short_p();
    chk("t6_0230", disp(), 16'h0230);
    long_press = 1'b1; short_press = 1'b1;
    step();
    long_press = 1'b0; short_press = 1'b0;
    chk("t6_stop_disp", disp(), 16'h0000);
    chk("t6_stop_run", {15'd0, running}, 16'd0);
    step();

    // RUN: long edge beats short -> LAP, lap latch captures pre-increment
    short_p();
    ticks(5);
    long_press = 1'b1; short_press = 1'b1; tick_1hz = 1'b1;
    step();
    long_press = 1'b0; short_press = 1'b0; tick_1hz = 1'b0;
    chk("t6_lap_prio", {14'd0, running, lap_mode}, 16'b11);
    chk("t6_lap_val", disp(), 16'h0005);
    short_p();
    chk("t6_live6", disp(), 16'h0006);

    // LAP: transition to STOP overrides a coincident tick
    long_p();
    long_press = 1'b1; tick_1hz = 1'b1;
    step();
    long_press = 1'b0; tick_1hz = 1'b0;
    chk("t6_lap_stop", disp(), 16'h0000);
    step();

    // reset mid-run
    short_p();
    ticks(7);
    chk("t6_pre_rst", disp(), 16'h0007);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_disp", disp(), 16'h0000);
    chk("t6_rst_run", {15'd0, running}, 16'd0);
    step();
    rst_n = 1'b1;
    ticks(3);
    chk("t6_after_rst", disp(), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
